// File: rtl/uart_rx_flow_pkg.sv
// Shared UART constants, receive FSM state encoding and the baud divisor helper.
package uart_rx_flow_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_START     = 3'd1,
    ST_DATA      = 3'd2,
    ST_STOP      = 3'd3,
    ST_WAIT_HIGH = 3'd4
  } rx_state_e;

  localparam int unsigned OVERSAMPLE = 16;
  localparam int unsigned MID_BIT    = 8;

  // Rounded clocks-per-oversample-tick; the transmitter uses the same divisor.
  function automatic int unsigned uart_div(input int unsigned clk_hz, input int unsigned baud);
    return (clk_hz + MID_BIT * baud) / (OVERSAMPLE * baud);
  endfunction

endpackage

// File: rtl/uart_rx_flow_sync_fifo.sv
// First-word-fall-through circular FIFO with push/pop, full/empty and occupancy.
module sync_fifo #(
  parameter  int Width = 8,
  parameter  int Depth = 16,
  localparam int CntW  = $clog2(Depth + 1),
  localparam int PtrW  = $clog2(Depth)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push_i,
  input  logic [Width-1:0] push_data_i,
  input  logic             pop_i,
  output logic [Width-1:0] pop_data_o,
  output logic             full_o,
  output logic             empty_o,
  output logic [CntW-1:0]  count_o,
  output logic [CntW-1:0]  count_next_o
);

  logic [Width-1:0] mem_q [Depth];
  logic [PtrW-1:0]  wr_q, wr_d, rd_q, rd_d;
  logic [CntW-1:0]  count_q, count_d;
  logic             push_ok, pop_ok;

  // A push into a full FIFO is still taken when the head leaves in the same cycle.
  always_comb begin
    pop_ok  = pop_i & (count_q != '0);
    push_ok = push_i & ((count_q != CntW'(Depth)) | pop_ok);
    wr_d    = push_ok ? wr_q + PtrW'(1) : wr_q;
    rd_d    = pop_ok ? rd_q + PtrW'(1) : rd_q;
    count_d = count_q;
    case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + CntW'(1);
      2'b01:   count_d = count_q - CntW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_q    <= '0;
      rd_q    <= '0;
      count_q <= '0;
    end else begin
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push_ok) mem_q[wr_q] <= push_data_i;
  end

  assign pop_data_o   = mem_q[rd_q];
  assign full_o       = (count_q == CntW'(Depth));
  assign empty_o      = (count_q == '0);
  assign count_o      = count_q;
  assign count_next_o = count_d;

endmodule

// File: rtl/uart_rx_flow.sv
// UART receiver with 16x oversampling, false-start rejection, byte FIFO and RTS
// hysteresis on FIFO occupancy.
//   state      | meaning
//   IDLE       | line idle, waiting for a low level
//   START      | validating start bit at mid-bit
//   DATA       | sampling 8 data bits, LSB first
//   STOP       | sampling stop bit, push or flag error
//   WAIT_HIGH  | after a framing error, wait for line to return high
module uart_rx_flow #(
  parameter int unsigned BaudRate             = 9600,
  parameter int unsigned SystemClockFrequency = 156250000,
  parameter int unsigned FifoDepth            = 16,
  parameter int unsigned RtsHighWater         = 12,
  parameter int unsigned RtsLowWater          = 4
) (
  input  logic                               i_clk,
  input  logic                               i_rst,
  input  logic                               i_uart_rx,
  output logic                               o_uart_rts_n,
  output logic                               o_rx_valid,
  output logic [7:0]                         o_rx_data,
  input  logic                               i_rx_ready,
  output logic [$clog2(FifoDepth+1)-1:0]     o_fifo_count,
  output logic                               o_frame_error,
  output logic                               o_overflow,
  output logic                               o_is_receiving
);
  import uart_rx_flow_pkg::*;

  localparam int unsigned    Div     = uart_div(SystemClockFrequency, BaudRate);
  localparam int             DivW    = (Div > 1) ? $clog2(Div) : 1;
  localparam logic [DivW-1:0] DivLoad = DivW'(Div - 1);
  localparam int             CntW    = $clog2(FifoDepth + 1);

  logic [1:0]      sync_q;
  logic            rx_s;
  logic [DivW-1:0] div_q, div_d;
  logic            tick;
  rx_state_e       state_q, state_d;
  logic [3:0]      tcnt_q, tcnt_d;
  logic [2:0]      bit_q, bit_d;
  logic [7:0]      shift_q, shift_d;
  logic            fe_q, fe_d, ov_q, ov_d, rts_q, rts_d;
  logic            push, pop, fifo_full, fifo_empty;
  logic [CntW-1:0] count_next;

  assign rx_s = sync_q[1];
  assign pop  = ~fifo_empty & i_rx_ready;

  always_comb begin
    tick    = (div_q == '0);
    div_d   = tick ? DivLoad : div_q - DivW'(1);
    state_d = state_q;
    tcnt_d  = tick ? tcnt_q + 4'd1 : tcnt_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    push    = 1'b0;
    fe_d    = 1'b0;
    ov_d    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        tcnt_d = '0;
        if (!rx_s) state_d = ST_START;
      end
      ST_START: begin
        if (tick && tcnt_q == 4'(MID_BIT - 1)) begin
          tcnt_d = '0;
          bit_d  = '0;
          state_d = rx_s ? ST_IDLE : ST_DATA;
        end
      end
      ST_DATA: begin
        // tcnt wraps to 0 on its own, keeping bit boundaries 16 ticks apart
        if (tick && tcnt_q == 4'(OVERSAMPLE - 1)) begin
          shift_d = {rx_s, shift_q[7:1]};
          bit_d   = bit_q + 3'd1;
          if (bit_q == 3'd7) state_d = ST_STOP;
        end
      end
      ST_STOP: begin
        if (tick && tcnt_q == 4'(OVERSAMPLE - 1)) begin
          if (rx_s) begin
            push    = 1'b1;
            ov_d    = fifo_full & ~pop;
            state_d = ST_IDLE;
          end else begin
            fe_d    = 1'b1;
            state_d = ST_WAIT_HIGH;
          end
        end
      end
      ST_WAIT_HIGH: begin
        if (rx_s) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    rts_d = rts_q;
    if (count_next >= CntW'(RtsHighWater))     rts_d = 1'b1;
    else if (count_next <= CntW'(RtsLowWater)) rts_d = 1'b0;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      sync_q  <= 2'b11;
      div_q   <= '0;
      state_q <= ST_IDLE;
      tcnt_q  <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      fe_q    <= 1'b0;
      ov_q    <= 1'b0;
      rts_q   <= 1'b0;
    end else begin
      sync_q  <= {sync_q[0], i_uart_rx};
      div_q   <= div_d;
      state_q <= state_d;
      tcnt_q  <= tcnt_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      fe_q    <= fe_d;
      ov_q    <= ov_d;
      rts_q   <= rts_d;
    end
  end

  sync_fifo #(
    .Width (8),
    .Depth (FifoDepth)
  ) u_fifo (
    .clk_i        (i_clk),
    .rst_i        (i_rst),
    .push_i       (push),
    .push_data_i  (shift_q),
    .pop_i        (pop),
    .pop_data_o   (o_rx_data),
    .full_o       (fifo_full),
    .empty_o      (fifo_empty),
    .count_o      (o_fifo_count),
    .count_next_o (count_next)
  );

  assign o_rx_valid     = ~fifo_empty;
  assign o_frame_error  = fe_q;
  assign o_overflow     = ov_q;
  assign o_uart_rts_n   = rts_q;
  assign o_is_receiving = (state_q != ST_IDLE);

endmodule

// File: tb/tb_uart_rx_flow.sv
// Directed-plus-random bench for uart_rx_flow at 64 clocks per bit (Div = 4).
module tb_uart_rx_flow;

  localparam int BIT = 64;

  logic       clk = 1'b0;
  logic       rst, rx, ready;
  logic       rts_n, valid, fe, ov, is_rx;
  logic [7:0] data;
  logic [4:0] count;

  always #5 clk = ~clk;

  uart_rx_flow #(
    .BaudRate             (9600),
    .SystemClockFrequency (64 * 9600),
    .FifoDepth            (16),
    .RtsHighWater         (12),
    .RtsLowWater          (4)
  ) dut (
    .i_clk          (clk),
    .i_rst          (rst),
    .i_uart_rx      (rx),
    .o_uart_rts_n   (rts_n),
    .o_rx_valid     (valid),
    .o_rx_data      (data),
    .i_rx_ready     (ready),
    .o_fifo_count   (count),
    .o_frame_error  (fe),
    .o_overflow     (ov),
    .o_is_receiving (is_rx)
  );

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Observations gathered at the negative edge, away from the active edge.
  logic [7:0] got_q[$];
  logic [7:0] model_q[$];
  int   valid_cycles = 0, fe_cycles = 0, ov_cycles = 0;
  int   rts_rise_at = -1, rts_fall_at = -1, last_cnt_change = 0, min_count = 99;
  int   launch_cyc = -1;
  logic rts_prev = 1'b0;
  logic [4:0] cnt_prev = '0;

  always @(negedge clk) begin
    if (rst === 1'b0) begin
      if (valid === 1'b1) valid_cycles++;
      if (valid === 1'b1 && ready === 1'b1) got_q.push_back(data);
      if (fe === 1'b1) fe_cycles++;
      if (ov === 1'b1) ov_cycles++;
      if (rts_n !== rts_prev) begin
        if (rts_n === 1'b1) rts_rise_at = int'(count);
        else                rts_fall_at = int'(count);
      end
      if (count !== cnt_prev) last_cnt_change = cyc;
      if (int'(count) < min_count) min_count = int'(count);
    end
    rts_prev = rts_n;
    cnt_prev = count;
  end

  initial begin
    #(700_000);
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop, input int hold);
    do begin @(posedge clk); #1; end while (cyc % 4 != 0);
    rx = 1'b0;
    launch_cyc = cyc;
    repeat (BIT) @(posedge clk);
    for (int i = 0; i < 8; i++) begin
      #1 rx = d[i];
      repeat (BIT) @(posedge clk);
    end
    #1 rx = stop;
    repeat (BIT + hold) @(posedge clk);
    #1;
    if (hold == 0) begin
      rx = 1'b1;
      repeat (8) @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_recv(input logic lvl, input int maxc, input string tag);
    int n = 0;
    while (is_rx !== lvl && n < maxc) begin @(posedge clk); #1; n++; end
    chk(tag, 32'(is_rx), 32'(lvl));
  endtask

  task automatic wait_count(input int val, input int maxc, input string tag);
    int n = 0;
    while (int'(count) != val && n < maxc) begin @(posedge clk); #1; n++; end
    chk(tag, 32'(count), 32'(val));
  endtask

  initial begin
    logic [7:0] b;
    int fe0, ov0, cal, target;

    rst = 1'b1; rx = 1'b1; ready = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_valid", 32'(valid), 32'd0);
    chk("rst_rts_n", 32'(rts_n), 32'd0);
    chk("rst_is_rx", 32'(is_rx), 32'd0);
    chk("rst_fe",    32'(fe),    32'd0);
    chk("rst_ov",    32'(ov),    32'd0);
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;

    // Single byte with consumer always ready
    ready = 1'b1; valid_cycles = 0; got_q.delete();
    send_frame(8'hA5, 1'b1, 0);
    chk("single_n",     32'(got_q.size()), 32'd1);
    chk("single_data",  32'(got_q[0]),     32'hA5);
    chk("single_vcyc",  32'(valid_cycles), 32'd1);
    chk("single_count", 32'(count),        32'd0);
    chk("single_fe",    32'(fe_cycles),    32'd0);
    chk("single_ov",    32'(ov_cycles),    32'd0);

    // Random bytes against a queue model
    got_q.delete(); model_q.delete();
    for (int i = 0; i < 4; i++) begin
      b = 8'($urandom_range(0, 255));
      model_q.push_back(b);
      send_frame(b, 1'b1, 0);
    end
    chk("rand_n", 32'(got_q.size()), 32'(model_q.size()));
    for (int i = 0; i < 4; i++) chk("rand_data", 32'(got_q[i]), 32'(model_q[i]));

    // False start: 4 ticks (16 clocks) low
    got_q.delete(); fe0 = fe_cycles;
    do begin @(posedge clk); #1; end while (cyc % 4 != 0);
    rx = 1'b0;
    repeat (8) @(posedge clk);
    #1 chk("fs_enter", 32'(is_rx), 32'd1);
    repeat (8) @(posedge clk);
    #1 rx = 1'b1;
    repeat (4) @(posedge clk);
    #1 chk("fs_hold_until_check", 32'(is_rx), 32'd1);
    wait_recv(1'b0, 64, "fs_idle");
    chk("fs_count", 32'(count),        32'd0);
    chk("fs_nopop", 32'(got_q.size()), 32'd0);
    chk("fs_fe",    32'(fe_cycles),    32'(fe0));

    // Framing error, line held low for 40 ticks, then a good byte
    fe0 = fe_cycles; ov0 = ov_cycles;
    send_frame(8'h3C, 1'b0, 160);
    chk("fe_pulse",     32'(fe_cycles), 32'(fe0 + 1));
    chk("fe_wait_high", 32'(is_rx),     32'd1);
    chk("fe_count",     32'(count),     32'd0);
    chk("fe_ov",        32'(ov_cycles), 32'(ov0));
    rx = 1'b1;
    wait_recv(1'b0, 16, "fe_release");
    send_frame(8'h11, 1'b1, 0);
    chk("fe_next_n",    32'(got_q.size()), 32'd1);
    chk("fe_next_data", 32'(got_q[0]),     32'h11);

    // Flow control: 14 bytes held, then drained
    ready = 1'b0; got_q.delete(); model_q.delete();
    rts_rise_at = -1; rts_fall_at = -1;
    for (int i = 0; i < 14; i++) begin
      model_q.push_back(8'(i));
      send_frame(8'(i), 1'b1, 0);
    end
    chk("fc_count",   32'(count),       32'd14);
    chk("fc_rts_hi",  32'(rts_n),       32'd1);
    chk("fc_rise_at", 32'(rts_rise_at), 32'd12);
    chk("fc_head",    32'(data),        32'h00);
    ready = 1'b1;
    wait_count(0, 64, "fc_drained");
    ready = 1'b0;
    chk("fc_n", 32'(got_q.size()), 32'(model_q.size()));
    for (int i = 0; i < 14; i++) chk("fc_order", 32'(got_q[i]), 32'(model_q[i]));
    chk("fc_fall_at", 32'(rts_fall_at), 32'd4);
    chk("fc_rts_lo",  32'(rts_n),       32'd0);

    // Overflow: 17 random bytes into a 16-deep FIFO
    got_q.delete(); model_q.delete(); ov0 = ov_cycles; cal = 0;
    for (int i = 0; i < 17; i++) begin
      b = 8'($urandom_range(0, 255));
      send_frame(b, 1'b1, 0);
      if (model_q.size() < 16) model_q.push_back(b);
      if (i == 15) cal = last_cnt_change - launch_cyc;
    end
    chk("ov_count", 32'(count),        32'd16);
    chk("ov_pulse", 32'(ov_cycles),    32'(ov0 + 1));
    chk("ov_head",  32'(data),         32'(model_q[0]));
    chk("ov_valid", 32'(valid),        32'd1);
    chk("ov_rts",   32'(rts_n),        32'd1);
    chk("ov_nopop", 32'(got_q.size()), 32'd0);

    // Pop in the very cycle of the push into a full FIFO
    b = 8'($urandom_range(0, 255));
    ov0 = ov_cycles; min_count = 99; launch_cyc = -1;
    fork
      send_frame(b, 1'b1, 0);
      begin
        do begin @(posedge clk); #1; end while (launch_cyc < 0);
        target = launch_cyc + cal;
        while (cyc < target - 1) begin @(posedge clk); #1; end
        ready = 1'b1;
        @(posedge clk);
        #1 ready = 1'b0;
      end
    join
    chk("pp_count",    32'(count),        32'd16);
    chk("pp_min",      32'(min_count),    32'd16);
    chk("pp_no_ov",    32'(ov_cycles),    32'(ov0));
    chk("pp_pop_n",    32'(got_q.size()), 32'd1);
    chk("pp_pop_data", 32'(got_q[0]),     32'(model_q[0]));
    void'(model_q.pop_front());
    model_q.push_back(b);
    chk("pp_new_head", 32'(data), 32'(model_q[0]));

    // Reset mid-frame with a full FIFO
    do begin @(posedge clk); #1; end while (cyc % 4 != 0);
    rx = 1'b0;
    repeat (200) @(posedge clk);
    #1 chk("mr_busy", 32'(is_rx), 32'd1);
    rst = 1'b1; rx = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    chk("mr_count", 32'(count), 32'd0);
    chk("mr_valid", 32'(valid), 32'd0);
    chk("mr_is_rx", 32'(is_rx), 32'd0);
    chk("mr_rts_n", 32'(rts_n), 32'd0);
    repeat (16) @(posedge clk);
    #1 chk("mr_stay_idle", 32'(is_rx), 32'd0);
    ready = 1'b1; got_q.delete(); fe0 = fe_cycles; ov0 = ov_cycles;
    send_frame(8'h5A, 1'b1, 0);
    chk("mr_next_n",    32'(got_q.size()), 32'd1);
    chk("mr_next_data", 32'(got_q[0]),     32'h5A);
    chk("mr_next_fe",   32'(fe_cycles),    32'(fe0));
    chk("mr_next_ov",   32'(ov_cycles),    32'(ov0));
    chk("mr_next_cnt",  32'(count),        32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/uart_rx_flow.md
# uart_rx_flow

UART receive front-end with a byte FIFO and hardware RTS flow control. It sits between the board's `i_uart_rx` and `o_uart_rts_n` pins and the downstream command/LED decoder, to which it hands received bytes over a valid/ready interface. It oversamples the line at 16x baud, rejects false starts, flags framing errors and overflow, and throttles the host through RTS hysteresis on FIFO occupancy.

## Interface
- `BaudRate`, 9600, line rate in bits/s
- `SystemClockFrequency`, 156250000, `i_clk` frequency in Hz
- `FifoDepth`, 16, FIFO entries; power of two, at least 4
- `RtsHighWater`, 12, occupancy at or above which RTS is deasserted
- `RtsLowWater`, 4, occupancy at or below which RTS is reasserted; must be less than `RtsHighWater`
- `i_clk` input 1: system clock
- `i_rst` input 1: reset, synchronous, active-high
- `i_uart_rx` input 1: asynchronous serial line, idles high
- `o_uart_rts_n` output 1: active-low request-to-send; 0 means the host may send
- `o_rx_valid` output 1: FIFO head is valid
- `o_rx_data` output 8: FIFO head byte, first-word-fall-through
- `i_rx_ready` input 1: consumer accepts the head byte this cycle
- `o_fifo_count` output clog2(FifoDepth+1): current occupancy
- `o_frame_error` output 1: one-cycle pulse when a stop bit samples 0
- `o_overflow` output 1: one-cycle pulse when a good byte is dropped because the FIFO is full
- `o_is_receiving` output 1: high in every FSM state except IDLE

## Operation
- **Synchronizer:** `i_uart_rx` passes through 2 flops, both reset to 1. The FSM sees only the synchronized value.
- **Tick generator:** a divisor counter pulses `tick` once every `Div` cycles.
  - `Div = (SystemClockFrequency + 8*BaudRate) / (16*BaudRate)` in integer arithmetic.
  - The counter is free-running and resets to 0.
- **FSM states:** IDLE, START, DATA, STOP, WAIT_HIGH. A 4-bit tick counter runs within a bit and a 3-bit counter indexes the data bit.
  - IDLE: when the synced rx is 0, go to START and clear the tick counter.
  - START: on the 8th tick, sample the line. If 1, it is a false start: return to IDLE. If 0, go to DATA with bit index 0.
  - DATA: every 16th tick, shift the sample into the shift register, LSB first. After bit 7, go to STOP.
  - STOP, on the 16th tick, sample the line:
    - Sample 1: push the byte, or pulse `o_overflow` if the push is refused. Then go to IDLE.
    - Sample 0: pulse `o_frame_error`, do not push, and go to WAIT_HIGH.
  - WAIT_HIGH: stay until the synced rx is 1, then go to IDLE. This prevents a break condition from being decoded as a stream of 0x00 bytes.
- **FIFO:** circular buffer of `FifoDepth` entries with read and write pointers that wrap at `FifoDepth`.
  - Push is accepted when `count < FifoDepth`, or when a pop occurs in the same cycle.
  - Pop occurs when `o_rx_valid & i_rx_ready`. Ready while empty is ignored.
  - Simultaneous push and pop leaves the count unchanged.
- **RTS:** registered.
  - Set to 1 when the next count is `>= RtsHighWater`.
  - Cleared to 0 when the next count is `<= RtsLowWater`.
  - Otherwise it holds its value.
  - Bytes already in flight are still accepted while RTS is high.
- **Reset values:**
  - Synchronizer flops: 1.
  - FSM: IDLE.
  - Pointers and `o_fifo_count`: 0.
  - `o_rx_valid`, `o_frame_error`, `o_overflow`, `o_is_receiving`, `o_uart_rts_n`: 0.
  - `o_rx_data`: don't-care while `o_rx_valid` is 0.
- **Reset mid-frame:** the partial byte is discarded, the FIFO contents are lost, and the FSM returns to IDLE on the next cycle.

## Timing
- Input latency: 2 cycles of synchronizer plus up to `Div` cycles of tick phase.
- The stop-bit sample falls 152 ticks after start-edge detection: 8 (mid-start) + 8×16 (data) + 16 (mid-stop).
- `o_rx_valid` and `o_fifo_count` update one cycle after the stop-sample tick.
- `o_frame_error` and `o_overflow` are high for exactly the one cycle after the stop-sample tick.
- After a pop, `o_rx_data` shows the next entry in the following cycle.
- `o_uart_rts_n` changes in the same cycle as the `o_fifo_count` update that crosses a watermark.
- The FIFO sustains one pop per cycle. At most one push occurs per byte time.

## Structure
- Shared include `uart_pkg.vh` holds:
  - FSM state encodings.
  - The divisor macro/function, which the UART transmitter reuses.
  - The 16x oversample constant and the mid-bit constant (8).
- Sub-module `sync_fifo`, parameterized by width and depth. It provides push, pop, full, empty and count, and is reusable for the TX path.
- RTS logic and the receive FSM stay in `uart_rx_flow`.

## Test plan
All scenarios use `SystemClockFrequency = 64*BaudRate`, which gives `Div = 4`, and `FifoDepth = 16`.
- **Single byte:** send frame 0xA5 with `i_rx_ready = 1`. Expect `o_rx_valid` for 1 cycle with `o_rx_data = 0xA5`, count returns to 0, and no error pulses.
- **False start:** pulse rx low for 4 ticks. Expect the FSM to return to IDLE, no push, and `o_is_receiving` to drop after the START check.
- **Framing error:** send 0x3C with the stop bit at 0 and rx held low for 40 ticks afterwards. Expect one `o_frame_error` pulse and no push. The FSM stays in WAIT_HIGH until rx rises, then the next byte 0x11 is received correctly.
- **Flow control:** send 14 bytes 0x00–0x0D with `i_rx_ready = 0`. Expect `o_uart_rts_n` to rise when count reaches 12 and count to end at 14. Then drain with ready = 1. Expect `o_uart_rts_n` to fall when count reaches 4 and data to come out in order.
- **Overflow:** send 17 bytes with ready = 0. Expect count to reach 16 and one `o_overflow` pulse on byte 17. The head stays byte 0, and byte 17 is absent.
- **Push/pop at full plus reset:** with the FIFO full, assert ready in the same cycle as a stop-sample push. Expect no overflow and count to stay at 16. Then assert `i_rst` mid-frame. Expect count 0, `o_rx_valid` 0 and FSM IDLE, and the next full frame 0x5A to be received cleanly.
